// File: rtl/sr_cmd_conditioner.sv
// Command conditioner for an SR flip-flop: synchronises and debounces two push buttons and
// converts each debounced rising edge into a one-cycle S or R pulse, never both at once.
module sr_cmd_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3,
    parameter int PRIORITY   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic set_lvl,
    output logic clr_lvl,
    output logic conflict
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_S = 2'd1,
        PEND_R = 2'd2
    } state_t;

    // Channel 0 carries set, channel 1 carries clear.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            lvl_q, lvl_d;
    logic [1:0]            lvl_dly_q, lvl_dly_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            req;
    state_t                state_q, state_d;
    logic                  s_q, s_d;
    logic                  r_q, r_d;
    logic                  conflict_q, conflict_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_dly_q  <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            lvl_dly_q  <= lvl_dly_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    always_comb begin
        sync1_d   = {clr_btn, set_btn};
        sync2_d   = sync1_q;
        lvl_dly_d = lvl_q;
        lvl_d     = lvl_q;
        cnt_d     = '0;
        for (int ch = 0; ch < 2; ch++) begin
            // A return to the accepted level before acceptance drops all accumulated credit.
            if (sync2_q[ch] != lvl_q[ch]) begin
                if (cnt_q[ch] == CNT_W'(DEB_CYCLES - 1)) begin
                    lvl_d[ch] = sync2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    assign req = lvl_q & ~lvl_dly_q;

    always_comb begin
        state_d    = state_q;
        s_d        = 1'b0;
        r_d        = 1'b0;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req[0] && req[1]) begin
                    conflict_d = 1'b1;
                    if (PRIORITY != 0) begin
                        s_d     = 1'b1;
                        state_d = PEND_R;
                    end else begin
                        r_d     = 1'b1;
                        state_d = PEND_S;
                    end
                end else begin
                    s_d = req[0];
                    r_d = req[1];
                end
            end
            // Debounce spacing guarantees no fresh request lands while a pulse is pending.
            PEND_S: begin
                s_d     = 1'b1;
                state_d = IDLE;
            end
            PEND_R: begin
                r_d     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign S        = s_q;
    assign R        = r_q;
    assign conflict = conflict_q;
    assign set_lvl  = lvl_q[0];
    assign clr_lvl  = lvl_q[1];

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Scoreboard bench for sr_cmd_conditioner: two instances (clear-first and set-first priority)
// share stimulus; a monitor pops expected pulses whenever S, R or conflict is presented.
module tb_sr_cmd_conditioner;

    typedef struct {
        int   cyc;
        logic s;
        logic r;
        logic c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic set_btn;
    logic clr_btn;
    logic [1:0] s_o, r_o, set_lvl_o, clr_lvl_o, conflict_o;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sr_cmd_conditioner #(.DEB_CYCLES(4), .CNT_W(3), .PRIORITY(0)) dut0 (
        .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
        .S(s_o[0]), .R(r_o[0]), .set_lvl(set_lvl_o[0]), .clr_lvl(clr_lvl_o[0]),
        .conflict(conflict_o[0])
    );

    sr_cmd_conditioner #(.DEB_CYCLES(4), .CNT_W(3), .PRIORITY(1)) dut1 (
        .clk(clk), .rst(rst), .set_btn(set_btn), .clr_btn(clr_btn),
        .S(s_o[1]), .R(r_o[1]), .set_lvl(set_lvl_o[1]), .clr_lvl(clr_lvl_o[1]),
        .conflict(conflict_o[1])
    );

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int d, input int c, input logic s, input logic r, input logic cf);
        exp_t e;
        e.cyc = c;
        e.s   = s;
        e.r   = r;
        e.c   = cf;
        exp_q[d].push_back(e);
    endtask

    task automatic check_idle(input string name);
        for (int d = 0; d < 2; d++) begin
            check({name, "_S"}, int'(s_o[d]), 0);
            check({name, "_R"}, int'(r_o[d]), 0);
            check({name, "_conflict"}, int'(conflict_o[d]), 0);
            check({name, "_set_lvl"}, int'(set_lvl_o[d]), 0);
            check({name, "_clr_lvl"}, int'(clr_lvl_o[d]), 0);
        end
    endtask

    // Monitor: pops one expectation per presented pulse; flags stale entries as missed pulses.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (s_o[d] & r_o[d]) begin
                check($sformatf("s_and_r_dut%0d", d), 1, 0);
            end
            while (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
                check($sformatf("missed_pulse_dut%0d", d), cyc, exp_q[d][0].cyc);
                void'(exp_q[d].pop_front());
            end
            if (s_o[d] | r_o[d] | conflict_o[d]) begin
                if (exp_q[d].size() == 0) begin
                    check($sformatf("unexpected_pulse_dut%0d", d),
                          int'({s_o[d], r_o[d], conflict_o[d]}), 0);
                end else begin
                    exp_t e;
                    e = exp_q[d].pop_front();
                    check($sformatf("pulse_cycle_dut%0d", d), cyc, e.cyc);
                    check($sformatf("pulse_S_dut%0d", d), int'(s_o[d]), int'(e.s));
                    check($sformatf("pulse_R_dut%0d", d), int'(r_o[d]), int'(e.r));
                    check($sformatf("pulse_conflict_dut%0d", d), int'(conflict_o[d]), int'(e.c));
                end
            end
        end
    end

    initial begin
        int c0;
        rst     = 1'b1;
        set_btn = 1'b1;
        clr_btn = 1'b1;

        // 1: reset holds everything low even with both buttons pressed.
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_idle("reset_hold");
        end
        set_btn = 1'b0;
        clr_btn = 1'b0;
        rst     = 1'b0;
        tick(10);

        // 2: clean set press; level at edge 6, pulse after edge 7, release is silent.
        c0 = cyc;
        set_btn = 1'b1;
        push(0, c0 + 7, 1'b1, 1'b0, 1'b0);
        push(1, c0 + 7, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("set_lvl_rise", int'(set_lvl_o[0]), (cyc >= c0 + 6) ? 1 : 0);
        end
        tick(2);
        set_btn = 1'b0;
        tick(12);
        check("set_lvl_release", int'(set_lvl_o[0]), 0);

        // 3: bouncing clear and a 3-clock glitch are both rejected.
        clr_btn = 1'b1; tick(1);
        clr_btn = 1'b0; tick(1);
        clr_btn = 1'b1; tick(1);
        clr_btn = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("clr_lvl_bounce", int'(clr_lvl_o[0]), 0);
        end
        clr_btn = 1'b1;
        tick(3);
        clr_btn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("clr_lvl_glitch", int'(clr_lvl_o[0]) | int'(clr_lvl_o[1]), 0);
        end

        // 4: simultaneous rise; winner with conflict in cycle 7, loser in cycle 8.
        c0 = cyc;
        set_btn = 1'b1;
        clr_btn = 1'b1;
        push(0, c0 + 7, 1'b0, 1'b1, 1'b1);
        push(0, c0 + 8, 1'b1, 1'b0, 1'b0);
        push(1, c0 + 7, 1'b1, 1'b0, 1'b1);
        push(1, c0 + 8, 1'b0, 1'b1, 1'b0);
        tick(12);
        check("both_lvl_set", int'(set_lvl_o[0] & clr_lvl_o[0]), 1);
        set_btn = 1'b0;
        clr_btn = 1'b0;
        tick(12);

        // 5: reset in cycle 7 discards the deferred pulse.
        c0 = cyc;
        set_btn = 1'b1;
        clr_btn = 1'b1;
        push(0, c0 + 7, 1'b0, 1'b1, 1'b1);
        push(1, c0 + 7, 1'b1, 1'b0, 1'b1);
        while (cyc < c0 + 7) tick(1);
        #1;
        rst     = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check_idle("mid_reset");
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check_idle("after_reset");
        end

        // 6: set held through reset release is a fresh rise at full latency.
        rst     = 1'b1;
        set_btn = 1'b1;
        tick(3);
        rst = 1'b0;
        c0  = cyc;
        push(0, c0 + 7, 1'b1, 1'b0, 1'b0);
        push(1, c0 + 7, 1'b1, 1'b0, 1'b0);
        tick(15);
        check("held_set_lvl", int'(set_lvl_o[1]), 1);
        set_btn = 1'b0;
        tick(10);

        check("queue_empty_dut0", exp_q[0].size(), 0);
        check("queue_empty_dut1", exp_q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
